tag_alloc_ctrl: RTL
===================

TAG_ALLOC_CTRL -- requirements
Module: tag_alloc_ctrl

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16, number of rows/tags; power of two, >=2.
REQ-003 SHALL have derived localparam TAG_WIDTH = $clog2(MAX_OUTSTANDING).
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  allocation request.
REQ-007 SHALL have port req_id  input  ID_WIDTH  AXI ID to store in the allocated row.
REQ-008 SHALL have port req_ready  output  1  allocation accepted this cycle.
REQ-009 SHALL have port grant_tag  output  TAG_WIDTH  row index granted; meaningful when req_valid && req_ready.
REQ-010 SHALL have port rel_valid  input  1  release request.
REQ-011 SHALL have port rel_tag  input  TAG_WIDTH  row to release.
REQ-012 SHALL have port rel_id  output  ID_WIDTH  stored ID of row rel_tag (combinational lookup).
REQ-013 SHALL have port count  output  TAG_WIDTH+1  number of used rows.
REQ-014 SHALL have ports full, empty  output  1 each  count==MAX_OUTSTANDING / count==0.
REQ-015 SHALL have port err  output  1  registered one-cycle pulse on illegal release.

Function
REQ-016 SHALL keep per row: used bit, stored id (ID_WIDTH); plus round-robin pointer rr_ptr (TAG_WIDTH).
REQ-017 SHALL drive req_ready = !full, combinationally from registered state only (no dependency on req_valid or rel_valid).
REQ-018 SHALL select grant_tag as the first row with used==0 searching rr_ptr, rr_ptr+1, ... modulo MAX_OUTSTANDING (wrap-around).
REQ-019 SHALL, on handshake (req_valid && req_ready), set used[grant_tag]=1 and id[grant_tag]=req_id at the next edge, and set rr_ptr = grant_tag+1 (mod MAX_OUTSTANDING).
REQ-020 SHALL leave rr_ptr and all rows unchanged when no handshake occurs.
REQ-021 SHALL, on rel_valid with used[rel_tag]==1, clear used[rel_tag] at the next edge; stored id is not cleared.
REQ-022 SHALL, on rel_valid with used[rel_tag]==0, change no state and assert err for exactly the following cycle.
REQ-023 SHALL base the allocation search on pre-edge state: a row released this cycle is not grantable until the next cycle.
REQ-024 SHALL, on simultaneous valid alloc and valid release, perform both; count unchanged.
REQ-025 SHALL, when full and rel_valid is legal, keep req_ready=0 that cycle; req_ready=1 the next cycle.
REQ-026 SHALL update count by +1 (alloc only), -1 (legal release only), 0 (both or neither); never wraps.
REQ-027 SHALL drive rel_id = id[rel_tag] regardless of rel_valid.
REQ-028 SHALL have single-cycle grant latency: grant_tag is valid in the handshake cycle; rel_id is valid in the release cycle.

Reset
REQ-029 SHALL, on rst assertion, asynchronously clear all used bits, ids to 0, rr_ptr to 0, count to 0, err to 0; hence req_ready=1, full=0, empty=1, grant_tag=0.
REQ-030 SHALL discard any handshake or release coinciding with rst asserted; state is operational from the first edge after rst deasserts.

Verification
REQ-031 SHALL cover: reset, then 3 back-to-back allocs with req_id 0xA,0xB,0xC -> grant_tag 0,1,2; count=3; rel_tag=1 -> rel_id=0xB.
REQ-032 SHALL cover: 16 allocs -> full=1, req_ready=0; 17th req_valid held -> no grant, count stays 16.
REQ-033 SHALL cover: full, release tag 5 with req_valid high -> no grant that cycle; next cycle grant_tag=5 (rr_ptr=0 after wrap, first free is 5); count back to 16.
REQ-034 SHALL cover: count=4 (tags 0-3), simultaneous alloc and release tag 2 -> grant_tag=4, count stays 4, tag 2 free next cycle.
REQ-035 SHALL cover: release of unused tag 9 -> err=1 for exactly one cycle, count and rows unchanged.
REQ-036 SHALL cover: rst asserted mid-stream asynchronously (between edges) with 7 rows used -> count=0, empty=1, req_ready=1 immediately; first alloc after release -> grant_tag=0.

Source files
------------

// File: rtl/tag_alloc_ctrl.sv
// Tag allocator: hands out free rows round-robin, stores an AXI ID per row,
// and frees rows on release with a registered error pulse on illegal release.
module tag_alloc_ctrl #(
  parameter  int ID_WIDTH        = 4,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int TAG_WIDTH       = $clog2(MAX_OUTSTANDING)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [ID_WIDTH-1:0]  req_id,
  output logic                 req_ready,
  output logic [TAG_WIDTH-1:0] grant_tag,
  input  logic                 rel_valid,
  input  logic [TAG_WIDTH-1:0] rel_tag,
  output logic [ID_WIDTH-1:0]  rel_id,
  output logic [TAG_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  localparam logic [TAG_WIDTH:0] MAX_CNT = (TAG_WIDTH+1)'(MAX_OUTSTANDING);
  localparam logic [TAG_WIDTH:0] ONE_CNT = (TAG_WIDTH+1)'(1);

  logic [MAX_OUTSTANDING-1:0] used_q, used_d;
  logic [ID_WIDTH-1:0]        id_q [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]        id_d [MAX_OUTSTANDING];
  logic [TAG_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TAG_WIDTH:0]         count_q, count_d;
  logic                       err_q, err_d;

  logic                       found;
  logic [TAG_WIDTH-1:0]       idx;
  logic                       alloc;
  logic                       rel_ok;

  assign count     = count_q;
  assign full      = (count_q == MAX_CNT);
  assign empty     = (count_q == '0);
  assign req_ready = !full;
  assign rel_id    = id_q[rel_tag];
  assign err       = err_q;

  // First free row at or after rr_ptr, wrapping; uses pre-edge state only.
  always_comb begin
    grant_tag = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      idx = rr_ptr_q + TAG_WIDTH'(i);
      if (!found && !used_q[idx]) begin
        found     = 1'b1;
        grant_tag = idx;
      end
    end
  end

  assign alloc  = req_valid && req_ready;
  assign rel_ok = rel_valid && used_q[rel_tag];

  always_comb begin
    used_d   = used_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    err_d    = rel_valid && !used_q[rel_tag];
    if (alloc) begin
      used_d[grant_tag] = 1'b1;
      id_d[grant_tag]   = req_id;
      rr_ptr_d          = grant_tag + TAG_WIDTH'(1);
    end
    // A legal release never targets the granted row, which is free.
    if (rel_ok) begin
      used_d[rel_tag] = 1'b0;
    end
    unique case ({alloc, rel_ok})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q   <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_q[i] <= '0;
      end
    end else begin
      used_q   <= used_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_q[i] <= id_d[i];
      end
    end
  end

endmodule
